// File: rtl/pc8001_mem_pkg.sv
// rtl/pc8001_mem_pkg.sv - shared state encoding and timing defaults for the SRAM arbiter
//
// Purpose: arbiter FSM state type, wait-counter geometry and the default
//          CPU wait / DMA burst limits used by sram_arbiter and cpu_wait_timer.
package pc8001_mem_pkg;

    localparam int unsigned WAIT_SLOW_DEFAULT = 25;
    localparam int unsigned WAIT_FAST_DEFAULT = 12;
    localparam int unsigned BURST_MAX_DEFAULT = 8;

    localparam int unsigned          WAIT_CNT_W   = 5;
    localparam logic [WAIT_CNT_W-1:0] WAIT_CNT_MAX = 5'd31;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CPU_ACC  = 3'd1,
        ST_CPU_DONE = 3'd2,
        ST_CPU_HOLD = 3'd3,
        ST_DMA      = 3'd4
    } arb_state_t;

endpackage

// File: rtl/cpu_wait_timer.sv
// rtl/cpu_wait_timer.sv - CPU wait-cycle counter and wait-request compare
//
// Purpose: counts cycles of an outstanding CPU request and holds cpu_wait
//          until the access is done and the minimum wait has elapsed.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   cpu_req     : CPU request level; counter clears while low
//   fast        : selects WAIT_FAST instead of WAIT_SLOW
//   done        : SRAM access for this request has completed
//   cpu_wait    : wait request back to the CPU
module cpu_wait_timer
    import pc8001_mem_pkg::*;
#(
    parameter int unsigned WAIT_SLOW = WAIT_SLOW_DEFAULT,
    parameter int unsigned WAIT_FAST = WAIT_FAST_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_req,
    input  logic fast,
    input  logic done,
    output logic cpu_wait
);

    logic [WAIT_CNT_W-1:0] count_q, count_d;
    logic [31:0]           wait_lim;
    logic                  lim_met;

    always_comb begin
        count_d = count_q;
        if (!cpu_req) begin
            count_d = '0;
        end else if (count_q != WAIT_CNT_MAX) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // fast is sampled live so a mid-wait toggle moves the threshold immediately
    assign wait_lim = fast ? WAIT_FAST : WAIT_SLOW;
    assign lim_met  = ({{(32-WAIT_CNT_W){1'b0}}, count_q} >= wait_lim);
    assign cpu_wait = cpu_req & ~(done & lim_met);

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - CPU / DMA arbiter for a single-port synchronous SRAM
//
// Purpose: shares one SRAM between a CPU (single accesses with a minimum
//          wait) and a DMA requester (back-to-back read beats), bounding
//          DMA bursts while the CPU is waiting.
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   fast                     : CPU wait profile select
//   cpu_req/we/adr/wdata     : CPU access request (level, held to the end)
//   cpu_rdata, cpu_wait      : registered read data, wait request
//   dma_req, dma_adr         : DMA beat request and address
//   dma_ack, dma_rdata       : one-cycle beat ack and its data
//   ram_adr/wdata/we, ram_q  : SRAM port, read data one cycle after address
module sram_arbiter
    import pc8001_mem_pkg::*;
#(
    parameter int unsigned BURST_MAX = BURST_MAX_DEFAULT,
    parameter int unsigned WAIT_SLOW = WAIT_SLOW_DEFAULT,
    parameter int unsigned WAIT_FAST = WAIT_FAST_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fast,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_adr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_wait,
    input  logic        dma_req,
    input  logic [15:0] dma_adr,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic [15:0] ram_adr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    input  logic [7:0]  ram_q
);

    localparam int unsigned          BEAT_W   = $clog2(BURST_MAX + 1);
    localparam logic [BEAT_W-1:0]    BEAT_SAT = BEAT_W'(BURST_MAX);

    arb_state_t        state_q, state_d;
    logic              starve_q, starve_d;
    logic              done_q, done_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [7:0]        cpu_rdata_q, cpu_rdata_d;
    logic [7:0]        dma_rdata_q, dma_rdata_d;
    logic              dma_ack_q, dma_ack_d;
    logic              burst_full;

    // The beat being issued this cycle is counted before the limit test
    assign burst_full = ((32'(beat_cnt_q) + 32'd1) >= BURST_MAX);

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        done_d      = done_q;
        beat_cnt_d  = beat_cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_ack_q ? ram_q : dma_rdata_q;
        dma_ack_d   = 1'b0;
        ram_adr     = cpu_adr;
        ram_wdata   = cpu_wdata;
        ram_we      = 1'b0;

        if (!cpu_req) begin
            done_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // A CPU that withdrew its request must not leave DMA locked out
                if (!cpu_req) begin
                    starve_d = 1'b0;
                end
                if (dma_req && !starve_q) begin
                    state_d    = ST_DMA;
                    beat_cnt_d = '0;
                end else if (cpu_req) begin
                    state_d = ST_CPU_ACC;
                end
            end
            ST_CPU_ACC: begin
                ram_we  = cpu_we;
                state_d = ST_CPU_DONE;
            end
            ST_CPU_DONE: begin
                cpu_rdata_d = ram_q;
                done_d      = 1'b1;
                starve_d    = 1'b0;
                state_d     = ST_CPU_HOLD;
            end
            ST_CPU_HOLD: begin
                if (!cpu_req) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DMA: begin
                if (!dma_req) begin
                    state_d = ST_IDLE;
                end else begin
                    ram_adr   = dma_adr;
                    dma_ack_d = 1'b1;
                    if (beat_cnt_q != BEAT_SAT) begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                    // Only a CPU still waiting for its access bounds the burst
                    if (cpu_req && !done_q && burst_full) begin
                        state_d  = ST_IDLE;
                        starve_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            starve_q    <= 1'b0;
            done_q      <= 1'b0;
            beat_cnt_q  <= '0;
            cpu_rdata_q <= 8'h00;
            dma_rdata_q <= 8'h00;
            dma_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            done_q      <= done_d;
            beat_cnt_q  <= beat_cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            dma_ack_q   <= dma_ack_d;
        end
    end

    cpu_wait_timer #(
        .WAIT_SLOW (WAIT_SLOW),
        .WAIT_FAST (WAIT_FAST)
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .cpu_req  (cpu_req),
        .fast     (fast),
        .done     (done_q),
        .cpu_wait (cpu_wait)
    );

    assign cpu_rdata = cpu_rdata_q;
    assign dma_ack   = dma_ack_q;
    // Beat data comes straight from the SRAM in the ack cycle, last beat otherwise
    assign dma_rdata = dma_ack_q ? ram_q : dma_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter
module tb_sram_arbiter;
    import pc8001_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        fast;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_adr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_wait;
    logic        dma_req;
    logic [15:0] dma_adr;
    logic        dma_ack;
    logic [7:0]  dma_rdata;
    logic [15:0] ram_adr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_q;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] dma_exp_q[$];
    logic [7:0] cpu_exp_q[$];

    logic [7:0] mem    [0:65535];
    bit         wr_vld [0:65535];

    always #5 clk = ~clk;

    sram_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .fast      (fast),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_adr   (cpu_adr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_wait  (cpu_wait),
        .dma_req   (dma_req),
        .dma_adr   (dma_adr),
        .dma_ack   (dma_ack),
        .dma_rdata (dma_rdata),
        .ram_adr   (ram_adr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_q     (ram_q)
    );

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h25;
    endfunction

    // Synchronous SRAM, read-before-write, one cycle read latency
    always @(posedge clk) begin
        ram_q <= wr_vld[ram_adr] ? mem[ram_adr] : init_val(ram_adr);
        if (ram_we) begin
            mem[ram_adr]    <= ram_wdata;
            wr_vld[ram_adr] <= 1'b1;
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (dut.state_q !== ST_IDLE) begin miscompares++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, ST_IDLE); end
        vectors++; if (cpu_wait !== 1'b0) begin miscompares++; $display("FAIL reset_cpu_wait: got %b want 0", cpu_wait); end
        vectors++; if (dma_ack !== 1'b0) begin miscompares++; $display("FAIL reset_dma_ack: got %b want 0", dma_ack); end
        vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
        vectors++; if (cpu_rdata !== 8'h00) begin miscompares++; $display("FAIL reset_cpu_rdata: got %h want 00", cpu_rdata); end
        vectors++; if (dma_rdata !== 8'h00) begin miscompares++; $display("FAIL reset_dma_rdata: got %h want 00", dma_rdata); end
        reset = 1'b0;
    endtask

    task automatic test_cpu_read();
        int n;
        logic fell;
        logic [7:0] exp;
        @(posedge clk); #1;
        fast = 1'b0; cpu_we = 1'b0; cpu_adr = 16'h8000; cpu_req = 1'b1;
        cpu_exp_q.push_back(8'hA5);
        n = 0; fell = 1'b0;
        while (!fell && n < 60) begin
            @(posedge clk); #1; n++;
            if (n == 1) begin
                vectors++; if (ram_adr !== 16'h8000) begin miscompares++; $display("FAIL read_ram_adr: got %h want 8000", ram_adr); end
            end
            if (cpu_wait === 1'b0) fell = 1'b1;
        end
        vectors++; if (!fell || n != 25) begin miscompares++; $display("FAIL read_wait_len: got %0d want 25", n); end
        exp = cpu_exp_q.pop_front();
        vectors++; if (cpu_rdata !== exp) begin miscompares++; $display("FAIL read_rdata: got %h want %h", cpu_rdata, exp); end
        cpu_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_cpu_write();
        int n;
        int pulses;
        logic fell;
        logic [7:0] exp;
        @(posedge clk); #1;
        fast = 1'b1; cpu_we = 1'b1; cpu_adr = 16'hC000; cpu_wdata = 8'h3C; cpu_req = 1'b1;
        n = 0; pulses = 0; fell = 1'b0;
        while (!fell && n < 60) begin
            @(posedge clk); #1; n++;
            if (ram_we === 1'b1) begin
                pulses++;
                vectors++; if (ram_adr !== 16'hC000 || ram_wdata !== 8'h3C) begin miscompares++; $display("FAIL write_bus: got %h/%h want c000/3c", ram_adr, ram_wdata); end
            end
            if (cpu_wait === 1'b0) fell = 1'b1;
        end
        vectors++; if (pulses != 1) begin miscompares++; $display("FAIL write_pulses: got %0d want 1", pulses); end
        vectors++; if (!fell || n != 12) begin miscompares++; $display("FAIL write_wait_len: got %0d want 12", n); end
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(posedge clk); #1;
        // read the location back through the arbiter
        cpu_adr = 16'hC000; cpu_req = 1'b1;
        cpu_exp_q.push_back(8'h3C);
        n = 0; fell = 1'b0;
        while (!fell && n < 60) begin
            @(posedge clk); #1; n++;
            vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("FAIL readback_we: got %b want 0", ram_we); end
            if (cpu_wait === 1'b0) fell = 1'b1;
        end
        exp = cpu_exp_q.pop_front();
        vectors++; if (!fell || cpu_rdata !== exp) begin miscompares++; $display("FAIL readback_rdata: got %h want %h", cpu_rdata, exp); end
        cpu_req = 1'b0; cpu_adr = 16'h8000;
        @(posedge clk); #1;
    endtask

    task automatic test_dma_burst(input int n_beats, input logic [15:0] base);
        int cyc, beats, acks, first_ack, last_ack;
        logic iss;
        logic [7:0] exp;
        @(posedge clk); #1;
        dma_adr = base; dma_req = 1'b1;
        cyc = 0; beats = 0; acks = 0; first_ack = -1; last_ack = -1; iss = 1'b0;
        while ((beats < n_beats || iss) && cyc < 200) begin
            @(posedge clk); #1; cyc++;
            vectors++; if (dma_ack !== iss) begin miscompares++; $display("FAIL dma_ack_timing: got %b want %b cyc %0d", dma_ack, iss, cyc); end
            if (dma_ack === 1'b1) begin
                acks++;
                if (first_ack < 0) first_ack = cyc;
                last_ack = cyc;
                exp = (dma_exp_q.size() > 0) ? dma_exp_q.pop_front() : 8'hxx;
                vectors++; if (dma_rdata !== exp) begin miscompares++; $display("FAIL dma_rdata: got %h want %h", dma_rdata, exp); end
                dma_adr = dma_adr + 16'd1;
            end
            if (beats == n_beats) dma_req = 1'b0;
            #1;
            iss = (dma_req === 1'b1) && (ram_adr === dma_adr) && (ram_we === 1'b0);
            if (iss) begin
                dma_exp_q.push_back(init_val(dma_adr));
                beats++;
            end
        end
        dma_req = 1'b0;
        vectors++; if (acks != n_beats) begin miscompares++; $display("FAIL dma_ack_count: got %0d want %0d", acks, n_beats); end
        vectors++; if (last_ack - first_ack + 1 != n_beats) begin miscompares++; $display("FAIL dma_gapless: got span %0d want %0d", last_ack - first_ack + 1, n_beats); end
    endtask

    task automatic test_dma_drop();
        test_dma_burst(3, 16'hF380);
        repeat (4) begin
            @(posedge clk); #1;
            vectors++; if (dma_ack !== 1'b0) begin miscompares++; $display("FAIL drop_spurious_ack: got %b want 0", dma_ack); end
        end
        vectors++; if (dut.state_q !== ST_IDLE) begin miscompares++; $display("FAIL drop_state: got %0d want %0d", dut.state_q, ST_IDLE); end
    endtask

    task automatic test_starve();
        int cyc, beats, beats_at_cpu;
        logic iss, cpu_seen;
        logic [7:0] exp;
        @(posedge clk); #1;
        fast = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h8000; cpu_req = 1'b1;
        dma_adr = 16'hF400; dma_req = 1'b1;
        cpu_exp_q.push_back(init_val(16'h8000));
        cyc = 0; beats = 0; beats_at_cpu = -1; iss = 1'b0; cpu_seen = 1'b0;
        while ((beats < 12 || iss) && cyc < 300) begin
            @(posedge clk); #1; cyc++;
            vectors++; if (dma_ack !== iss) begin miscompares++; $display("FAIL starve_ack_timing: got %b want %b cyc %0d", dma_ack, iss, cyc); end
            if (dma_ack === 1'b1) begin
                exp = (dma_exp_q.size() > 0) ? dma_exp_q.pop_front() : 8'hxx;
                vectors++; if (dma_rdata !== exp) begin miscompares++; $display("FAIL starve_dma_rdata: got %h want %h", dma_rdata, exp); end
                dma_adr = dma_adr + 16'd1;
            end
            if (cpu_req && cpu_wait === 1'b0 && !cpu_seen) begin
                cpu_seen = 1'b1;
                beats_at_cpu = beats;
                exp = cpu_exp_q.pop_front();
                vectors++; if (cpu_rdata !== exp) begin miscompares++; $display("FAIL starve_cpu_rdata: got %h want %h", cpu_rdata, exp); end
                cpu_req = 1'b0;
            end
            if (beats == 12) dma_req = 1'b0;
            #1;
            iss = (dma_req === 1'b1) && (ram_adr === dma_adr) && (ram_we === 1'b0);
            if (iss) begin
                dma_exp_q.push_back(init_val(dma_adr));
                beats++;
            end
        end
        dma_req = 1'b0; cpu_req = 1'b0;
        vectors++; if (beats_at_cpu != 8) begin miscompares++; $display("FAIL starve_beats_before_cpu: got %0d want 8", beats_at_cpu); end
        vectors++; if (beats != 12) begin miscompares++; $display("FAIL starve_dma_resume: got %0d want 12", beats); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_burst();
        int cyc, beats;
        logic iss;
        @(posedge clk); #1;
        cpu_req = 1'b0; dma_adr = 16'hF500; dma_req = 1'b1;
        cyc = 0; beats = 0; iss = 1'b0;
        while (beats < 5 && cyc < 50) begin
            @(posedge clk); #1; cyc++;
            if (dma_ack === 1'b1) dma_adr = dma_adr + 16'd1;
            #1;
            iss = (dma_req === 1'b1) && (ram_adr === dma_adr) && (ram_we === 1'b0);
            if (iss) beats++;
        end
        vectors++; if (beats != 5) begin miscompares++; $display("FAIL rst_burst_reach: got %0d want 5", beats); end
        reset = 1'b1;
        @(posedge clk); #1;
        vectors++; if (dma_ack !== 1'b0) begin miscompares++; $display("FAIL rst_dma_ack: got %b want 0", dma_ack); end
        vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("FAIL rst_ram_we: got %b want 0", ram_we); end
        vectors++; if (cpu_wait !== 1'b0) begin miscompares++; $display("FAIL rst_cpu_wait: got %b want 0", cpu_wait); end
        vectors++; if (dut.state_q !== ST_IDLE) begin miscompares++; $display("FAIL rst_state: got %0d want %0d", dut.state_q, ST_IDLE); end
        vectors++; if (cpu_rdata !== 8'h00) begin miscompares++; $display("FAIL rst_cpu_rdata: got %h want 00", cpu_rdata); end
        vectors++; if (dma_rdata !== 8'h00) begin miscompares++; $display("FAIL rst_dma_rdata: got %h want 00", dma_rdata); end
        reset = 1'b0; dma_req = 1'b0;
        @(posedge clk); #1;
        vectors++; if (dma_ack !== 1'b0 || ram_we !== 1'b0) begin miscompares++; $display("FAIL rst_after: got ack %b we %b want 0 0", dma_ack, ram_we); end
    endtask

    initial begin
        reset = 1'b1; fast = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_adr = 16'h8000; cpu_wdata = 8'h00; dma_req = 1'b0; dma_adr = 16'h0000;
        test_reset();
        test_cpu_read();
        test_cpu_write();
        test_dma_burst(20, 16'hF300);
        test_dma_drop();
        test_starve();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
